gf_poly_mul_seq: RTL and testbench

GF_POLY_MUL_SEQ -- requirements
Module: gf_poly_mul_seq

---
 rtl/gf_poly_mul_seq.sv | 141 ++++++++++++++
 tb/tb_gf_poly_mul_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gf_poly_mul_seq.sv
// gf_poly_mul_seq: sequential GF(2^SIZE) polynomial multiply-accumulate, one p coefficient per cycle

// gf_mul: combinational GF(2^SIZE) multiplier, reduced by a fixed primitive polynomial
module gf_mul #(
    parameter int m    = 255,
    parameter int SIZE = $clog2(m)
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] y
);
    // low SIZE bits of the primitive polynomial; the x^SIZE term is implicit
    localparam logic [SIZE-1:0] red_poly =
        SIZE == 2 ? SIZE'(3) :
        SIZE == 3 ? SIZE'(3) :
        SIZE == 4 ? SIZE'(3) :
        SIZE == 5 ? SIZE'(5) :
        SIZE == 6 ? SIZE'(3) :
        SIZE == 7 ? SIZE'(9) :
                    SIZE'(8'h1d);

    logic [SIZE-1:0] sum;
    logic [SIZE-1:0] sh;

    // shift-and-add multiply, reducing a after every doubling
    always_comb begin
        sum = '0;
        sh = a;
        for (int k = 0; k < SIZE; k++) begin
            sum = b[k] ? sum ^ sh : sum;
            sh = sh[SIZE-1] ? (sh << 1) ^ red_poly : sh << 1;
        end
    end

    assign y = sum;
endmodule

module gf_poly_mul_seq #(
    parameter int m                = 255,
    parameter int SIZE             = $clog2(m),
    parameter int n                = 2,
    parameter int flat_size        = (n + 1) * SIZE,
    parameter int large_array_size = (2 * n + 1) * SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        acc_mode,
    input  logic [flat_size-1:0]        flat_p,
    input  logic [flat_size-1:0]        flat_q,
    output logic [large_array_size-1:0] flat_z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);
    localparam int iw = (n > 0) ? $clog2(n + 1) : 1;
    localparam logic [iw-1:0] i_last = iw'(n);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [iw-1:0]   i;
    logic [SIZE-1:0] p       [0:n];
    logic [SIZE-1:0] q       [0:n];
    logic [SIZE-1:0] prod    [0:n];
    logic [SIZE-1:0] acc     [0:2*n];
    logic [SIZE-1:0] acc_nxt [0:2*n];
    logic [SIZE-1:0] p_i;

    // select the p coefficient for the current row
    always_comb begin
        p_i = '0;
        for (int j = 0; j <= n; j++)
            p_i = (iw'(j) == i) ? p[j] : p_i;
    end

    for (genvar j = 0; j <= n; j++) begin : g_mul
        gf_mul #(.m(m), .SIZE(SIZE)) u_mul (.a(p_i), .b(q[j]), .y(prod[j]));
    end

    // fold row i of partial products into acc[i..i+n]
    always_comb begin
        for (int k = 0; k <= 2 * n; k++)
            acc_nxt[k] = acc[k];
        for (int j = 0; j <= n; j++)
            for (int k = 0; k <= 2 * n; k++)
                acc_nxt[k] = (k == int'(i) + j) ? acc_nxt[k] ^ prod[j] : acc_nxt[k];
    end

    for (genvar k = 0; k <= 2 * n; k++) begin : g_z
        assign flat_z[k*SIZE +: SIZE] = acc[k];
    end

    // control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i <= '0;
            in_ready <= 1'b1;
            busy <= 1'b0;
            out_valid <= 1'b0;
            for (int j = 0; j <= n; j++) begin
                p[j] <= '0;
                q[j] <= '0;
            end
            for (int k = 0; k <= 2 * n; k++)
                acc[k] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int j = 0; j <= n; j++) begin
                        p[j] <= flat_p[j*SIZE +: SIZE];
                        q[j] <= flat_q[j*SIZE +: SIZE];
                    end
                    for (int k = 0; k <= 2 * n; k++)
                        acc[k] <= acc_mode ? acc[k] : '0;
                    i <= '0;
                    state <= RUN;
                    in_ready <= 1'b0;
                    busy <= 1'b1;
                end
                RUN: begin
                    for (int k = 0; k <= 2 * n; k++)
                        acc[k] <= acc_nxt[k];
                    i <= (i == i_last) ? '0 : i + 1'b1;
                    if (i == i_last) begin
                        state <= DONE;
                        busy <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf_poly_mul_seq.sv
// tb_gf_poly_mul_seq: random and directed checks of gf_poly_mul_seq against a log/antilog model
module tb_gf_poly_mul_seq;
    localparam int N = 2;
    localparam int FW = 24;
    localparam int ZW = 40;

    logic clk = 0, rst = 1, in_valid = 0, acc_mode = 0, out_ready = 0;
    logic [FW-1:0] flat_p = '0, flat_q = '0;
    logic in_ready, out_valid, busy;
    logic [ZW-1:0] flat_z;

    int errors = 0, checks = 0;
    bit started = 0;
    logic [7:0] ex [0:254];
    int lg [0:255];
    int ph = 0, cnt = 0;
    logic [ZW-1:0] mz = '0;
    logic [ZW-1:0] z;

    gf_poly_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .acc_mode(acc_mode), .flat_p(flat_p), .flat_q(flat_q), .flat_z(flat_z),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        return (a == 0 || b == 0) ? 8'd0 : ex[(lg[a] + lg[b]) % 255];
    endfunction

    function automatic logic [ZW-1:0] model_op(input logic [ZW-1:0] base, input logic [FW-1:0] fp,
                                               input logic [FW-1:0] fq, input logic mode);
        logic [ZW-1:0] r;
        r = mode ? base : '0;
        for (int a = 0; a <= N; a++)
            for (int b = 0; b <= N; b++)
                r[(a+b)*8 +: 8] = r[(a+b)*8 +: 8] ^ gmul(fp[a*8 +: 8], fq[b*8 +: 8]);
        return r;
    endfunction

    // reference: 0 idle, 1 running for N+1 cycles, 2 holding the result
    always @(posedge clk) begin
        if (rst) begin
            ph <= 0;
            cnt <= 0;
            mz <= '0;
        end else if (ph == 0) begin
            if (in_valid) begin
                mz <= model_op(mz, flat_p, flat_q, acc_mode);
                ph <= 1;
                cnt <= 0;
            end
        end else if (ph == 1) begin
            cnt <= cnt + 1;
            if (cnt == N) ph <= 2;
        end else if (out_ready) begin
            ph <= 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_in_ready", in_ready, ph == 0);
            check("m_busy", busy, ph == 1);
            check("m_out_valid", out_valid, ph == 2);
            if (ph != 1) check("m_flat_z", flat_z, mz);
        end
    end

    task automatic run_op(input logic [FW-1:0] fp, input logic [FW-1:0] fq, input logic mode,
                          input int hold, input bit bp, input string name, output logic [ZW-1:0] res);
        int c;
        c = 0;
        @(negedge clk);
        in_valid = 1; flat_p = fp; flat_q = fq; acc_mode = mode;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; flat_p = FW'($urandom); flat_q = FW'($urandom); acc_mode = 1'($urandom);
        while (!out_valid && c < 20) begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        check({name, "_latency"}, c, 3);
        res = flat_z;
        for (int h = 0; h < hold; h++) begin
            in_valid = bp; flat_p = FW'($urandom); flat_q = FW'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (bp) begin
                check({name, "_bp_z"}, flat_z, res);
                check({name, "_bp_ready"}, in_ready, 0);
            end
        end
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        check({name, "_release_ready"}, in_ready, 1);
        check({name, "_release_valid"}, out_valid, 0);
        in_valid = 0;
    endtask

    initial begin
        ex[0] = 8'd1;
        lg[0] = 0;
        lg[1] = 0;
        for (int k = 1; k < 255; k++)
            ex[k] = ex[k-1][7] ? (ex[k-1] << 1) ^ 8'h1d : ex[k-1] << 1;
        for (int k = 0; k < 255; k++)
            lg[ex[k]] = k;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_flat_z", flat_z, 0);
        started = 1;

        check("pin_identity", model_op('0, 24'h000001, 24'h090705, 0), 40'h0000090705);
        check("pin_reduction", model_op('0, 24'h000002, 24'h000080, 0), 40'h000000001d);
        check("pin_char2", model_op('0, 24'h000101, 24'h000101, 0), 40'h0000010001);

        run_op(24'h000001, 24'h090705, 0, 0, 0, "identity", z);
        check("identity_z", z, 40'h0000090705);
        run_op(24'h000001, 24'h090705, 1, 0, 0, "accumulate", z);
        check("accumulate_z", z, 40'h0);
        run_op(24'h000002, 24'h000080, 0, 1, 0, "reduction", z);
        check("reduction_z", z, 40'h000000001d);
        run_op(24'h000101, 24'h000101, 0, 2, 0, "char2", z);
        check("char2_z", z, 40'h0000010001);
        run_op(24'h0a0b0c, 24'h112233, 0, 10, 1, "backpressure", z);
        check("backpressure_z", z, model_op('0, 24'h0a0b0c, 24'h112233, 0));

        @(negedge clk);
        in_valid = 1; flat_p = 24'h050403; flat_q = 24'h080706; acc_mode = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_flat_z", flat_z, 0);
        run_op(24'h050403, 24'h080706, 1, 0, 0, "after_rst", z);
        check("after_rst_z", z, model_op('0, 24'h050403, 24'h080706, 0));

        for (int t = 0; t < 150; t++)
            run_op(FW'($urandom), FW'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), "rand", z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
